// File: rtl/spike_fifo_arbiter_if.sv
// FIFO write-port bundle between the spike arbiter (master) and the spike-event FIFO (slave).
// The master drives the write strobe and event word and watches the FIFO full flag.
interface spike_fifo_arbiter_if #(
    parameter int TS_WIDTH  = 12,
    parameter int IDX_WIDTH = 4
);
    logic                          wr;
    logic [TS_WIDTH+IDX_WIDTH-1:0] data_out;
    logic                          fifo_full;

    modport master (
        output wr,
        output data_out,
        input  fifo_full
    );

    modport slave (
        input  wr,
        input  data_out,
        output fifo_full
    );
endinterface

// File: rtl/spike_fifo_arbiter.sv
// Round-robin scheduler that latches per-neuron spike pulses and writes one
// {timestamp, neuron index} event per cycle into the spike-event FIFO.
module spike_fifo_arbiter #(
    parameter int N_NEURONS = 16,
    parameter int IDX_WIDTH = 4,
    parameter int TS_WIDTH  = 12,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_NEURONS-1:0] spike_in,
    input  logic                 tick,
    spike_fifo_arbiter_if.master fifo,
    output logic                 pending_any,
    output logic [CNT_WIDTH-1:0] drop_cnt,
    output logic                 drop_pulse
);

    logic [N_NEURONS-1:0] pending;
    logic [IDX_WIDTH-1:0] rr_ptr;
    logic [TS_WIDTH-1:0]  ts;

    logic [IDX_WIDTH-1:0] winner;
    logic                 found;
    logic                 grant;
    logic [N_NEURONS-1:0] grant_mask;
    logic [N_NEURONS-1:0] drops;
    logic [IDX_WIDTH:0]   drop_num;
    logic [CNT_WIDTH:0]   drop_sum;

    // Index arithmetic wraps naturally because N_NEURONS is a power of two.
    always_comb begin
        winner = rr_ptr;
        found  = 1'b0;
        for (int k = 0; k < N_NEURONS; k++) begin
            if (!found && pending[rr_ptr + IDX_WIDTH'(k)]) begin
                winner = rr_ptr + IDX_WIDTH'(k);
                found  = 1'b1;
            end
        end
    end

    assign pending_any   = |pending;
    assign grant         = ~reset & pending_any & ~fifo.fifo_full;
    assign fifo.wr       = grant;
    assign fifo.data_out = {ts, winner};

    // A spike on the neuron being granted this cycle just re-arms it, so it is masked out of drops.
    always_comb begin
        grant_mask = grant ? (N_NEURONS'(1) << winner) : '0;
        drops      = spike_in & pending & ~grant_mask;
        drop_num   = '0;
        for (int i = 0; i < N_NEURONS; i++) begin
            drop_num = drop_num + {{IDX_WIDTH{1'b0}}, drops[i]};
        end
        drop_sum = {1'b0, drop_cnt} + (CNT_WIDTH+1)'(drop_num);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending    <= '0;
            rr_ptr     <= '0;
            ts         <= '0;
            drop_cnt   <= '0;
            drop_pulse <= 1'b0;
        end else begin
            pending <= (pending & ~grant_mask) | spike_in;
            if (grant) begin
                rr_ptr <= winner + IDX_WIDTH'(1);
            end
            if (tick) begin
                ts <= ts + TS_WIDTH'(1);
            end
            drop_cnt   <= drop_sum[CNT_WIDTH] ? '1 : drop_sum[CNT_WIDTH-1:0];
            drop_pulse <= |drops;
        end
    end

endmodule

// File: tb/tb_spike_fifo_arbiter.sv
// Self-checking bench for spike_fifo_arbiter: directed vector table, hand-written
// corner sequences and randomized traffic, all compared against a behavioural model.
module tb_spike_fifo_arbiter;

    localparam int N    = 16;
    localparam int TSW  = 12;
    localparam int CNTW = 16;
    localparam int TS_MOD  = 1 << TSW;
    localparam int CNT_MAX = (1 << CNTW) - 1;

    logic            clk;
    logic            reset;
    logic [N-1:0]    spike_in;
    logic            tick;
    logic            pending_any;
    logic [CNTW-1:0] drop_cnt;
    logic            drop_pulse;

    int tests_run;
    int tests_failed;
    bit checking_on;

    spike_fifo_arbiter_if #(.TS_WIDTH(TSW), .IDX_WIDTH(4)) bus ();

    spike_fifo_arbiter #(
        .N_NEURONS(N),
        .IDX_WIDTH(4),
        .TS_WIDTH (TSW),
        .CNT_WIDTH(CNTW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .spike_in   (spike_in),
        .tick       (tick),
        .fifo       (bus),
        .pending_any(pending_any),
        .drop_cnt   (drop_cnt),
        .drop_pulse (drop_pulse)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    // Behavioural model: a set of waiting neurons, a next-turn pointer, a timestamp and a drop tally.
    bit m_pend [N];
    int m_ptr;
    int m_ts;
    int m_drop;
    bit m_pulse;

    function automatic int model_winner();
        for (int k = 0; k < N; k++) begin
            if (m_pend[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, compare outputs to the model before the edge, then advance the model.
    task automatic apply_stimulus(input logic [N-1:0] sp, input logic tk, input logic full, input logic rst);
        int  w;
        bit  any;
        bit  exp_wr;
        int  exp_data;
        int  ndrop;
        @(negedge clk);
        spike_in      = sp;
        tick          = tk;
        bus.fifo_full = full;
        reset         = rst;
        #1;
        w        = model_winner();
        any      = (w >= 0);
        exp_wr   = !rst && any && !full;
        exp_data = m_ts * N + (any ? w : m_ptr);
        if (checking_on) begin
            check_output("model_wr", 32'(bus.wr), 32'(exp_wr));
            check_output("model_data", 32'(bus.data_out), 32'(exp_data));
            check_output("model_pending_any", 32'(pending_any), 32'(any));
            check_output("model_drop_cnt", 32'(drop_cnt), 32'(m_drop));
            check_output("model_drop_pulse", 32'(drop_pulse), 32'(m_pulse));
        end
        if (rst) begin
            foreach (m_pend[i]) m_pend[i] = 1'b0;
            m_ptr   = 0;
            m_ts    = 0;
            m_drop  = 0;
            m_pulse = 1'b0;
        end else begin
            ndrop = 0;
            for (int i = 0; i < N; i++) begin
                bit granted;
                granted = exp_wr && (w == i);
                if (sp[i] && m_pend[i] && !granted) ndrop++;
                if (granted) m_pend[i] = 1'b0;
                if (sp[i]) m_pend[i] = 1'b1;
            end
            if (exp_wr) m_ptr = (w + 1) % N;
            if (tk) m_ts = (m_ts + 1) % TS_MOD;
            m_drop  = (m_drop + ndrop > CNT_MAX) ? CNT_MAX : m_drop + ndrop;
            m_pulse = (ndrop > 0);
        end
    endtask

    typedef struct {
        logic [N-1:0] spike;
        logic         tick;
        logic         full;
        logic         exp_wr;
        logic [15:0]  exp_data;
        logic         exp_pany;
        logic [15:0]  exp_drop;
        logic         exp_pulse;
    } vec_t;

    vec_t vecs [23];

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        checking_on  = 1'b0;
        spike_in      = '0;
        tick          = 1'b0;
        bus.fifo_full = 1'b0;
        reset         = 1'b1;

        // Expected outputs are those seen in the same cycle the inputs are applied.
        vecs[0]  = '{16'h0001, 0, 0, 0, 16'h0000, 0, 16'd0, 0};
        vecs[1]  = '{16'h0000, 0, 0, 1, 16'h0000, 1, 16'd0, 0};
        vecs[2]  = '{16'h0000, 0, 0, 0, 16'h0001, 0, 16'd0, 0};
        vecs[3]  = '{16'h0010, 0, 0, 0, 16'h0001, 0, 16'd0, 0};
        vecs[4]  = '{16'h0208, 0, 0, 1, 16'h0004, 1, 16'd0, 0};
        vecs[5]  = '{16'h0000, 0, 0, 1, 16'h0009, 1, 16'd0, 0};
        vecs[6]  = '{16'h0410, 0, 0, 1, 16'h0003, 1, 16'd0, 0};
        vecs[7]  = '{16'h0000, 0, 0, 1, 16'h0004, 1, 16'd0, 0};
        vecs[8]  = '{16'h0000, 0, 0, 1, 16'h000A, 1, 16'd0, 0};
        vecs[9]  = '{16'h0000, 0, 0, 0, 16'h000B, 0, 16'd0, 0};
        vecs[10] = '{16'h0004, 0, 1, 0, 16'h000B, 0, 16'd0, 0};
        vecs[11] = '{16'h0000, 0, 1, 0, 16'h0002, 1, 16'd0, 0};
        vecs[12] = '{16'h0004, 0, 1, 0, 16'h0002, 1, 16'd0, 0};
        vecs[13] = '{16'h0000, 0, 1, 0, 16'h0002, 1, 16'd1, 1};
        vecs[14] = '{16'h0000, 0, 0, 1, 16'h0002, 1, 16'd1, 0};
        vecs[15] = '{16'h0000, 0, 0, 0, 16'h0003, 0, 16'd1, 0};
        vecs[16] = '{16'h0020, 0, 0, 0, 16'h0003, 0, 16'd1, 0};
        vecs[17] = '{16'h0020, 0, 0, 1, 16'h0005, 1, 16'd1, 0};
        vecs[18] = '{16'h0000, 0, 0, 1, 16'h0005, 1, 16'd1, 0};
        vecs[19] = '{16'h0000, 0, 0, 0, 16'h0006, 0, 16'd1, 0};
        vecs[20] = '{16'h0080, 1, 0, 0, 16'h0006, 0, 16'd1, 0};
        vecs[21] = '{16'h0000, 1, 0, 1, 16'h0017, 1, 16'd1, 0};
        vecs[22] = '{16'h0000, 0, 0, 0, 16'h0028, 0, 16'd1, 0};

        apply_stimulus('0, 1'b0, 1'b0, 1'b1);
        checking_on = 1'b1;
        apply_stimulus('0, 1'b0, 1'b0, 1'b1);
        apply_stimulus('0, 1'b0, 1'b0, 1'b0);
        check_output("reset_wr", 32'(bus.wr), 32'd0);
        check_output("reset_data", 32'(bus.data_out), 32'd0);
        check_output("reset_drop_cnt", 32'(drop_cnt), 32'd0);

        for (int v = 0; v < 23; v++) begin
            apply_stimulus(vecs[v].spike, vecs[v].tick, vecs[v].full, 1'b0);
            check_output($sformatf("vec%0d_wr", v), 32'(bus.wr), 32'(vecs[v].exp_wr));
            check_output($sformatf("vec%0d_data", v), 32'(bus.data_out), 32'(vecs[v].exp_data));
            check_output($sformatf("vec%0d_pany", v), 32'(pending_any), 32'(vecs[v].exp_pany));
            check_output($sformatf("vec%0d_drop", v), 32'(drop_cnt), 32'(vecs[v].exp_drop));
            check_output($sformatf("vec%0d_pulse", v), 32'(drop_pulse), 32'(vecs[v].exp_pulse));
        end

        // All neurons at once drain in index order from pointer 0.
        apply_stimulus('0, 1'b0, 1'b0, 1'b1);
        apply_stimulus(16'hFFFF, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < N; k++) begin
            apply_stimulus('0, 1'b0, 1'b0, 1'b0);
            check_output($sformatf("burst_wr%0d", k), 32'(bus.wr), 32'd1);
            check_output($sformatf("burst_idx%0d", k), 32'(bus.data_out), 32'(k));
        end
        apply_stimulus('0, 1'b0, 1'b0, 1'b0);
        check_output("burst_done_pany", 32'(pending_any), 32'd0);
        check_output("burst_done_ptr", 32'(bus.data_out), 32'd0);

        // Timestamp wraps after 4097 ticks.
        apply_stimulus('0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 4097; k++) apply_stimulus('0, 1'b1, 1'b0, 1'b0);
        apply_stimulus(16'h0002, 1'b0, 1'b0, 1'b0);
        apply_stimulus('0, 1'b0, 1'b0, 1'b0);
        check_output("ts_wrap_wr", 32'(bus.wr), 32'd1);
        check_output("ts_wrap_data", 32'(bus.data_out), 32'h0011);

        // Mid-stream reset with five pending neurons and seven drops.
        apply_stimulus(16'h001F, 1'b0, 1'b1, 1'b0);
        apply_stimulus(16'h001F, 1'b0, 1'b1, 1'b0);
        apply_stimulus(16'h0003, 1'b0, 1'b1, 1'b0);
        apply_stimulus('0, 1'b0, 1'b0, 1'b0);
        check_output("pre_reset_drop", 32'(drop_cnt), 32'd7);
        check_output("pre_reset_wr", 32'(bus.wr), 32'd1);
        apply_stimulus(16'hFFFF, 1'b1, 1'b0, 1'b1);
        check_output("reset_cycle_wr", 32'(bus.wr), 32'd0);
        apply_stimulus(16'h0040, 1'b0, 1'b0, 1'b0);
        check_output("post_reset_pany", 32'(pending_any), 32'd0);
        check_output("post_reset_drop", 32'(drop_cnt), 32'd0);
        check_output("post_reset_data", 32'(bus.data_out), 32'd0);
        apply_stimulus('0, 1'b0, 1'b0, 1'b0);
        check_output("post_reset_wr", 32'(bus.wr), 32'd1);
        check_output("post_reset_idx6", 32'(bus.data_out), 32'h0006);

        // Drop counter saturation under a permanently full FIFO.
        apply_stimulus('0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 4200; k++) apply_stimulus(16'hFFFF, 1'b0, 1'b1, 1'b0);
        apply_stimulus('0, 1'b0, 1'b1, 1'b0);
        check_output("drop_saturated", 32'(drop_cnt), 32'hFFFF);

        // Randomized traffic against the model.
        apply_stimulus('0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 3000; k++) begin
            logic [N-1:0] sp;
            sp = N'($urandom & $urandom & $urandom);
            apply_stimulus(sp, ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
                           ($urandom_range(0, 199) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/spike_fifo_arbiter.md
# spike_fifo_arbiter

Round-robin write scheduler between the spiking neuron array and the spike-event FIFO. It latches single-cycle spike pulses from N_NEURONS neurons into a pending vector and grants one pending neuron per cycle onto the FIFO write port. Each grant writes a {timestamp, neuron index} event word and respects the FIFO full flag. Spikes that collide with an already-pending spike from the same neuron are dropped and counted.

## Interface
Parameters:
- N_NEURONS, 16, number of spike requesters; power of two, ≥2
- IDX_WIDTH, 4, neuron index width, = log2(N_NEURONS)
- TS_WIDTH, 12, timestep counter width
- CNT_WIDTH, 16, drop counter width

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- spike_in  in  N_NEURONS  per-neuron spike pulses, any number per cycle
- tick  in  1  timestep advance pulse
- fifo_full  in  1  FIFO full flag; a write is accepted only when low
- wr  out  1  FIFO write strobe
- data_out  out  TS_WIDTH+IDX_WIDTH  event word {ts[TS_WIDTH-1:0], idx[IDX_WIDTH-1:0]}
- pending_any  out  1  OR of the pending vector
- drop_cnt  out  CNT_WIDTH  saturating count of dropped spikes
- drop_pulse  out  1  registered; high one cycle after any cycle with ≥1 drop

## Operation
- State: pending[N_NEURONS-1:0], rr_ptr[IDX_WIDTH-1:0], ts[TS_WIDTH-1:0], drop_cnt, drop_pulse. No other FSM; the arbiter is a combinational search over the registered state.
- Arbitration: search pending starting at rr_ptr, ascending, wrapping from N_NEURONS-1 to 0. The first set bit is the winner g.
- wr = ~reset & pending_any & ~fifo_full. data_out = {ts, g} whenever pending_any is high; data_out = {ts, rr_ptr} otherwise. Both are combinational from registers plus fifo_full.
- grant = wr. On grant: pending[g] is cleared and rr_ptr <= g+1 (mod N_NEURONS). With no grant, rr_ptr holds.
- Pending update per bit: pending[i] <= (pending[i] & ~(grant & g==i)) | spike_in[i].
- A spike on the neuron granted in the same cycle re-sets its pending bit and is not a drop.
- Drop condition per bit: spike_in[i] & pending[i] & ~(grant & g==i).
- drop_cnt += popcount of drops, saturating at 2^CNT_WIDTH-1.
- drop_pulse <= |drops.
- ts increments on tick and wraps modulo 2^TS_WIDTH. A write in the same cycle as tick carries the pre-increment ts.
- fifo_full high: no grant. Pending bits keep accumulating and drops keep being counted. rr_ptr and ts behave normally.
- Reset, including mid-operation, takes effect on the next edge:
  - pending, rr_ptr, ts, drop_cnt and drop_pulse go to 0.
  - wr is forced low during the reset cycle.
  - spike_in and tick are ignored during the reset cycle.

## Timing
- Reset values: wr=0, data_out=0, pending_any=0, drop_cnt=0, drop_pulse=0.
- Latency: a spike_in pulse at cycle t sets pending at edge t. wr for that neuron can be high in cycle t+1 at the earliest.
- Throughput: one event per cycle while pending_any & ~fifo_full.
- Fairness: with all N_NEURONS pending continuously, each neuron is granted exactly once per N_NEURONS consecutive grants.
- Handshake: the write is complete at the rising edge where wr=1. fifo_full is sampled in the same cycle, so no write is issued into a full FIFO.
- Drop accounting: drop_cnt reflects a drop one cycle after the colliding spike. drop_pulse follows on the same schedule.

## Test plan
- Reset, then spike_in=16'h0001 at cycle 1, fifo_full=0 -> wr=1 at cycle 2 with data_out={12'd0,4'd0}; pending_any=0 at cycle 3; drop_cnt=0.
- spike_in=16'hFFFF for one cycle, fifo_full=0 -> 16 consecutive writes with idx 0,1,…,15. Then rr_ptr=0 and pending_any=0.
- Pending={3,9}, rr_ptr=5 -> first grant idx 9, then idx 3 (wrap). Then a new spike on 4 and 10 -> next grant idx 4.
- fifo_full=1 while neuron 2 spikes at cycles 1 and 3 -> wr stays 0; drop_cnt=1 after cycle 4; drop_pulse high in cycle 4. Releasing full gives one write with idx 2.
- tick pulsed 4097 times with TS_WIDTH=12, then one spike -> event ts=1 (wrap). A write coincident with tick carries the old ts.
- Mid-stream reset with 5 pending bits and drop_cnt=7 -> wr=0 in the reset cycle; next cycle pending_any=0, drop_cnt=0, ts=0; the next spike on 6 writes idx 6 with ts 0.
